// File: rtl/axi_lite_to_bp_lite_client_if.sv
// AXI4-Lite bus bundle between an AXI-Lite master and the BedRock I/O client.
//
// Ports (all carried as interface signals):
//   AW channel : awaddr, awprot, awvalid, awready
//   W  channel : wdata, wstrb, wvalid, wready
//   B  channel : bresp, bvalid, bready
//   AR channel : araddr, arprot, arvalid, arready
//   R  channel : rdata, rresp, rvalid, rready
// Modports:
//   master : the side that issues transactions (e.g. a PCIe/UART bridge)
//   slave  : the side that answers them (axi_lite_to_bp_lite_client)
interface axi_lite_to_bp_lite_client_if #(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64
);
    logic [addr_width_p-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;

    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;

    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [addr_width_p-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;

    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_to_bp_lite_client.sv
// AXI4-Lite subordinate that turns AXI-Lite reads/writes into BedRock uncached
// I/O commands and converts the matching I/O responses back into R/B beats.
// Only one transaction is in flight at a time.
//
// The BedRock configuration values (paddr_width_p, cce_block_width_p,
// lce_id_width_p, lce_assoc_p) are given directly as parameters; their defaults
// match the default BlackParrot configuration.
//
// Ports:
//   aclk_i, aresetn_i      : clock, asynchronous active-low reset
//   s_axi_lite (slave)     : AXI4-Lite AW/W/B/AR/R channels
//   io_cmd_o/_v_o/_ready_i : BedRock command out (ready/valid, held while valid)
//   io_resp_i/_v_i/_yumi_o : BedRock response in (valid/yumi)
module axi_lite_to_bp_lite_client #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int axi_data_width_p  = 64,
    parameter int axi_addr_width_p  = 64,
    localparam int payload_width_lp = lce_id_width_p + $clog2(lce_assoc_p),
    localparam int header_width_lp  = 4 + 4 + paddr_width_p + 3 + payload_width_lp,
    localparam int bp_in_mem_msg_width_lp = header_width_lp + cce_block_width_p
) (
    input  logic                              aclk_i,
    input  logic                              aresetn_i,
    axi_lite_to_bp_lite_client_if.slave       s_axi_lite,
    output logic [bp_in_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                              io_cmd_v_o,
    input  logic                              io_cmd_ready_i,
    input  logic [bp_in_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                              io_resp_v_i,
    output logic                              io_resp_yumi_o
);
    localparam int strb_width_lp = axi_data_width_p / 8;

    if (axi_data_width_p != 32 && axi_data_width_p != 64) begin : g_bad_width
        $error("axi_data_width_p must be 32 or 64");
    end

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1 = 3'd0,
        e_bedrock_msg_size_2 = 3'd1,
        e_bedrock_msg_size_4 = 3'd2,
        e_bedrock_msg_size_8 = 3'd3
    } msg_size_e;

    typedef struct packed {
        logic [payload_width_lp-1:0] payload;
        logic [2:0]                  size;
        logic [paddr_width_p-1:0]    addr;
        logic [3:0]                  subop;
        logic [3:0]                  msg_type;
    } mem_header_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        mem_header_s                  header;
    } mem_msg_s;

    typedef enum logic [2:0] {
        e_wait, e_wr_cmd, e_rd_cmd, e_wr_resp, e_rd_resp, e_b, e_r
    } state_e;

    state_e                     state_r, state_n;
    logic                       aw_v_r, w_v_r;
    logic [paddr_width_p-1:0]   awaddr_r, araddr_r;
    logic [axi_data_width_p-1:0] wdata_r, rdata_r;
    logic [strb_width_lp-1:0]   wstrb_r;
    logic [1:0]                 bresp_r;
    logic                       in_wait, aw_hs, w_hs, ar_hs;
    mem_msg_s                   cmd, resp;
    logic                       unused_bits;

    // Readies are only offered while idle and never while reset is held.
    // Reads yield to any write that is already captured or being presented.
    assign in_wait              = (state_r == e_wait) & aresetn_i;
    assign s_axi_lite.awready   = in_wait & ~aw_v_r;
    assign s_axi_lite.wready    = in_wait & ~w_v_r;
    assign s_axi_lite.arready   = in_wait & ~aw_v_r & ~w_v_r
                                & ~s_axi_lite.awvalid & ~s_axi_lite.wvalid;
    assign aw_hs = s_axi_lite.awvalid & s_axi_lite.awready;
    assign w_hs  = s_axi_lite.wvalid  & s_axi_lite.wready;
    assign ar_hs = s_axi_lite.arvalid & s_axi_lite.arready;

    assign s_axi_lite.bresp = bresp_r;
    assign s_axi_lite.rdata = rdata_r;
    assign s_axi_lite.rresp = 2'b00;
    assign io_cmd_o         = cmd;
    assign resp             = io_resp_i;

    assign unused_bits = ^{s_axi_lite.awprot, s_axi_lite.arprot,
                           s_axi_lite.awaddr, s_axi_lite.araddr, resp};

    // Write strobe decode: the strobe must be a single contiguous run whose
    // length is a legal BedRock size. Adding the lowest set bit to the strobe
    // clears the whole run only if the run is contiguous.
    logic [3:0]               strb_cnt;
    logic [strb_width_lp:0]   strb_ext, strb_sum;
    logic                     strb_ok;
    logic [2:0]               wr_size;
    always_comb begin
        strb_cnt = '0;
        for (int i = 0; i < strb_width_lp; i++) begin
            strb_cnt = strb_cnt + {3'b000, wstrb_r[i]};
        end
        strb_ext = {1'b0, wstrb_r};
        strb_sum = strb_ext + (strb_ext & (~strb_ext + 1'b1));
        strb_ok  = ((strb_sum & strb_ext) == '0);
        wr_size  = e_bedrock_msg_size_1;
        case (strb_cnt)
            4'd1:    wr_size = e_bedrock_msg_size_1;
            4'd2:    wr_size = e_bedrock_msg_size_2;
            4'd4:    wr_size = e_bedrock_msg_size_4;
            4'd8:    wr_size = e_bedrock_msg_size_8;
            default: strb_ok = 1'b0;
        endcase
    end

    // Next-state and output decode. The command is built only from captured
    // registers so it stays stable for as long as it is being offered.
    always_comb begin
        state_n           = state_r;
        cmd               = '0;
        io_cmd_v_o        = 1'b0;
        io_resp_yumi_o    = 1'b0;
        s_axi_lite.bvalid = 1'b0;
        s_axi_lite.rvalid = 1'b0;
        case (state_r)
            e_wait: begin
                if ((aw_v_r | aw_hs) & (w_v_r | w_hs)) begin
                    state_n = e_wr_cmd;
                end else if (ar_hs) begin
                    state_n = e_rd_cmd;
                end
            end
            e_wr_cmd: begin
                if (!strb_ok) begin
                    state_n = e_b;
                end else begin
                    io_cmd_v_o          = 1'b1;
                    cmd.header.msg_type = e_bedrock_mem_uc_wr;
                    cmd.header.addr     = awaddr_r;
                    cmd.header.size     = wr_size;
                    cmd.data[axi_data_width_p-1:0] = wdata_r;
                    if (io_cmd_ready_i) state_n = e_wr_resp;
                end
            end
            e_rd_cmd: begin
                io_cmd_v_o          = 1'b1;
                cmd.header.msg_type = e_bedrock_mem_uc_rd;
                cmd.header.addr     = araddr_r;
                cmd.header.size     = (axi_data_width_p == 64) ? e_bedrock_msg_size_8
                                                               : e_bedrock_msg_size_4;
                if (io_cmd_ready_i) state_n = e_rd_resp;
            end
            e_wr_resp: begin
                io_resp_yumi_o = io_resp_v_i;
                if (io_resp_v_i) state_n = e_b;
            end
            e_rd_resp: begin
                io_resp_yumi_o = io_resp_v_i;
                if (io_resp_v_i) state_n = e_r;
            end
            e_b: begin
                s_axi_lite.bvalid = 1'b1;
                if (s_axi_lite.bready) state_n = e_wait;
            end
            e_r: begin
                s_axi_lite.rvalid = 1'b1;
                if (s_axi_lite.rready) state_n = e_wait;
            end
            default: state_n = e_wait;
        endcase
    end

    // State and payload registers. Reset drops whatever was in flight, so a
    // response arriving after reset finds the FSM idle and is left alone.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_r  <= e_wait;
            aw_v_r   <= 1'b0;
            w_v_r    <= 1'b0;
            awaddr_r <= '0;
            araddr_r <= '0;
            wdata_r  <= '0;
            wstrb_r  <= '0;
            bresp_r  <= 2'b00;
            rdata_r  <= '0;
        end else begin
            state_r <= state_n;
            if (aw_hs) begin
                aw_v_r   <= 1'b1;
                awaddr_r <= s_axi_lite.awaddr[paddr_width_p-1:0];
            end
            if (w_hs) begin
                w_v_r   <= 1'b1;
                wdata_r <= s_axi_lite.wdata;
                wstrb_r <= s_axi_lite.wstrb;
            end
            if (ar_hs) begin
                araddr_r <= s_axi_lite.araddr[paddr_width_p-1:0];
            end
            if (state_r == e_wr_cmd && !strb_ok) begin
                bresp_r <= 2'b10;
            end
            if (state_r == e_wr_resp && io_resp_v_i) begin
                bresp_r <= 2'b00;
            end
            if (state_r == e_rd_resp && io_resp_v_i) begin
                rdata_r <= resp.data[axi_data_width_p-1:0];
            end
            if (state_r == e_b && s_axi_lite.bready) begin
                aw_v_r <= 1'b0;
                w_v_r  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_to_bp_lite_client.sv
// Self-checking bench for axi_lite_to_bp_lite_client. Expected commands,
// write responses and read data are queued when stimulus is driven and popped
// when the DUT produces them. Inputs change right after the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_axi_lite_to_bp_lite_client;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int PADDR = 40;
    localparam int BLK   = 512;
    localparam int HDR   = 4 + 4 + PADDR + 3 + 7;
    localparam int MSGW  = HDR + BLK;
    localparam logic [3:0] UC_RD = 4'd2;
    localparam logic [3:0] UC_WR = 4'd3;
    localparam logic [2:0] SZ_2 = 3'd1;
    localparam logic [2:0] SZ_4 = 3'd2;
    localparam logic [2:0] SZ_8 = 3'd3;

    typedef struct {
        logic [3:0]       mtype;
        logic [PADDR-1:0] addr;
        logic [2:0]       size;
        logic [DW-1:0]    data;
    } exp_cmd_t;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [MSGW-1:0] io_cmd;
    logic            io_cmd_v;
    logic            io_cmd_ready;
    logic [MSGW-1:0] io_resp;
    logic            io_resp_v;
    logic            io_resp_yumi;

    int n_checks = 0;
    int n_fail = 0;
    int cmd_hs_cnt = 0;
    int yumi_cnt = 0;

    exp_cmd_t      cmd_q[$];
    logic [1:0]    bresp_q[$];
    logic [DW-1:0] rdata_q[$];

    axi_lite_to_bp_lite_client_if #(.addr_width_p(AW), .data_width_p(DW)) axi ();

    axi_lite_to_bp_lite_client #(
        .paddr_width_p(PADDR), .cce_block_width_p(BLK), .lce_id_width_p(4),
        .lce_assoc_p(8), .axi_data_width_p(DW), .axi_addr_width_p(AW)
    ) dut (
        .aclk_i(aclk),
        .aresetn_i(aresetn),
        .s_axi_lite(axi),
        .io_cmd_o(io_cmd),
        .io_cmd_v_o(io_cmd_v),
        .io_cmd_ready_i(io_cmd_ready),
        .io_resp_i(io_resp),
        .io_resp_v_i(io_resp_v),
        .io_resp_yumi_o(io_resp_yumi)
    );

    always #5 aclk = ~aclk;

    // Count command and response handshakes at the same sampling point the
    // tests use, so every transfer the DUT completes is accounted for.
    always @(negedge aclk) begin
        #1;
        if (aresetn && io_cmd_v && io_cmd_ready) cmd_hs_cnt <= cmd_hs_cnt + 1;
        if (aresetn && io_resp_yumi) yumi_cnt <= yumi_cnt + 1;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference encoding of a BedRock uncached command: everything not set
    // explicitly is zero.
    function automatic logic [MSGW-1:0] build_cmd(input exp_cmd_t e);
        logic [MSGW-1:0] m;
        m = '0;
        m[3:0]            = e.mtype;
        m[8 +: PADDR]     = e.addr;
        m[8 + PADDR +: 3] = e.size;
        m[HDR +: DW]      = e.data;
        return m;
    endfunction

    // Wait (bounded) until a DUT output goes high: 0=io_cmd_v, 1=bvalid, 2=rvalid.
    task automatic wait_out(input int which, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if ((which == 0 && io_cmd_v === 1'b1) ||
                (which == 1 && axi.bvalid === 1'b1) ||
                (which == 2 && axi.rvalid === 1'b1)) begin
                seen = 1'b1;
                break;
            end
            @(negedge aclk); #1;
        end
    endtask

    // Present an I/O response with a junk header and junk upper data until it
    // is taken, then withdraw it.
    task automatic send_resp(input logic [DW-1:0] d, output bit seen);
        @(negedge aclk);
        io_resp = '1;
        io_resp[HDR +: DW] = d;
        io_resp_v = 1'b1;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (io_resp_yumi === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge aclk); #1;
        end
        @(negedge aclk);
        io_resp_v = 1'b0;
        io_resp = '0;
        #1;
    endtask

    task automatic finish_b();
        @(negedge aclk); axi.bready = 1'b1; #1;
        @(negedge aclk); axi.bready = 1'b0; #1;
    endtask

    task automatic test_reset();
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        io_cmd_ready = 1'b0; io_resp_v = 1'b0; io_resp = '0;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_readies: got %b expected 000", {axi.awready, axi.wready, axi.arready});
        end
        n_checks++;
        if ({axi.bvalid, axi.rvalid, io_cmd_v, io_resp_yumi} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_valids: got %b expected 0000", {axi.bvalid, axi.rvalid, io_cmd_v, io_resp_yumi});
        end
        n_checks++;
        if ({axi.bresp, axi.rresp, axi.rdata} !== 68'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_payload: got %h expected 0", {axi.bresp, axi.rresp, axi.rdata});
        end
        n_checks++;
        if (io_cmd !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_io_cmd: got %h expected 0", io_cmd);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL idle_readies: got %b expected 111", {axi.awready, axi.wready, axi.arready});
        end
    endtask

    task automatic test_write_aw_first();
        exp_cmd_t e;
        bit seen;
        logic [1:0] eb;
        io_cmd_ready = 1'b1;
        @(negedge aclk);
        axi.awaddr = 64'h1000; axi.awvalid = 1'b1;
        #1;
        n_checks++;
        if (axi.awready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL aw_ready: got %b expected 1", axi.awready);
        end
        @(negedge aclk);
        axi.awvalid = 1'b0;
        #1;
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL aw_captured_readies: got %b expected 010", {axi.awready, axi.wready, axi.arready});
        end
        repeat (2) begin
            @(negedge aclk); #1;
            n_checks++;
            if (io_cmd_v !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL cmd_before_w: got %b expected 0", io_cmd_v);
            end
        end
        @(negedge aclk);
        axi.wdata = 64'hDEADBEEF; axi.wstrb = 8'h0F; axi.wvalid = 1'b1;
        cmd_q.push_back('{UC_WR, 40'h1000, SZ_4, 64'hDEADBEEF});
        bresp_q.push_back(2'b00);
        #1;
        @(negedge aclk);
        axi.wvalid = 1'b0;
        #1;
        n_checks++;
        if (io_cmd_v !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_cmd_latency: got %b expected 1", io_cmd_v);
        end else begin
            e = cmd_q.pop_front();
            n_checks++;
            if (io_cmd !== build_cmd(e)) begin
                n_fail++;
                $display("[TB] FAIL wr_cmd_payload: got %h expected %h", io_cmd, build_cmd(e));
            end
        end
        send_resp(64'h0, seen);
        n_checks++;
        if (seen !== 1'b1 || axi.bvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_bvalid_latency: yumi %b bvalid %b expected 1 1", seen, axi.bvalid);
        end else begin
            eb = bresp_q.pop_front();
            n_checks++;
            if (axi.bresp !== eb) begin
                n_fail++;
                $display("[TB] FAIL wr_bresp: got %b expected %b", axi.bresp, eb);
            end
        end
        finish_b();
        n_checks++;
        if ({axi.awready, axi.wready, axi.bvalid} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL wr_done_readies: got %b expected 110", {axi.awready, axi.wready, axi.bvalid});
        end
    endtask

    task automatic test_simultaneous();
        exp_cmd_t e;
        bit seen;
        logic [DW-1:0] er;
        @(negedge aclk);
        axi.awaddr = 64'h40; axi.awvalid = 1'b1;
        axi.wdata = 64'h1122334455667788; axi.wstrb = 8'hFF; axi.wvalid = 1'b1;
        axi.araddr = 64'h2000; axi.arvalid = 1'b1;
        cmd_q.push_back('{UC_WR, 40'h40, SZ_8, 64'h1122334455667788});
        cmd_q.push_back('{UC_RD, 40'h2000, SZ_8, 64'h0});
        #1;
        n_checks++;
        if (axi.arready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ar_blocked_same_cycle: got %b expected 0", axi.arready);
        end
        @(negedge aclk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        #1;
        wait_out(0, seen);
        e = cmd_q.pop_front();
        n_checks++;
        if (seen !== 1'b1 || io_cmd !== build_cmd(e)) begin
            n_fail++;
            $display("[TB] FAIL simul_wr_cmd: got %h expected %h", io_cmd, build_cmd(e));
        end
        send_resp(64'h0, seen);
        wait_out(1, seen);
        n_checks++;
        if (seen !== 1'b1 || axi.arready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ar_blocked_during_b: bvalid %b arready %b expected 1 0", seen, axi.arready);
        end
        void'(bresp_q.size());
        finish_b();
        n_checks++;
        if (axi.arready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ar_after_b: got %b expected 1", axi.arready);
        end
        @(negedge aclk);
        axi.arvalid = 1'b0;
        #1;
        wait_out(0, seen);
        e = cmd_q.pop_front();
        n_checks++;
        if (seen !== 1'b1 || io_cmd !== build_cmd(e)) begin
            n_fail++;
            $display("[TB] FAIL simul_rd_cmd: got %h expected %h", io_cmd, build_cmd(e));
        end
        rdata_q.push_back(64'hCAFEF00D5555AAAA);
        send_resp(64'hCAFEF00D5555AAAA, seen);
        wait_out(2, seen);
        er = rdata_q.pop_front();
        n_checks++;
        if (seen !== 1'b1 || axi.rdata !== er) begin
            n_fail++;
            $display("[TB] FAIL simul_rdata: got %h expected %h", axi.rdata, er);
        end
        @(negedge aclk); axi.rready = 1'b1; #1;
        @(negedge aclk); axi.rready = 1'b0; #1;
    endtask

    task automatic test_read_hold();
        exp_cmd_t e;
        bit seen;
        logic [DW-1:0] er;
        @(negedge aclk);
        axi.araddr = 64'h2008; axi.arvalid = 1'b1;
        cmd_q.push_back('{UC_RD, 40'h2008, SZ_8, 64'h0});
        #1;
        @(negedge aclk);
        axi.arvalid = 1'b0;
        #1;
        e = cmd_q.pop_front();
        n_checks++;
        if (io_cmd_v !== 1'b1 || io_cmd !== build_cmd(e)) begin
            n_fail++;
            $display("[TB] FAIL rd_cmd: v %b got %h expected %h", io_cmd_v, io_cmd, build_cmd(e));
        end
        rdata_q.push_back(64'h0123456789ABCDEF);
        send_resp(64'h0123456789ABCDEF, seen);
        er = rdata_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge aclk); #1;
            end
            n_checks++;
            if ({axi.rvalid, axi.rresp, axi.rdata} !== {1'b1, 2'b00, er}) begin
                n_fail++;
                $display("[TB] FAIL rd_hold_%0d: got %b %b %h expected 1 00 %h", i, axi.rvalid, axi.rresp, axi.rdata, er);
            end
        end
        @(negedge aclk);
        axi.rready = 1'b1;
        #1;
        n_checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== er) begin
            n_fail++;
            $display("[TB] FAIL rd_fourth_cycle: rvalid %b rdata %h expected 1 %h", axi.rvalid, axi.rdata, er);
        end
        @(negedge aclk);
        axi.rready = 1'b0;
        #1;
        n_checks++;
        if ({axi.rvalid, axi.arready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL rd_done: got %b expected 01", {axi.rvalid, axi.arready});
        end
    endtask

    task automatic test_backpressure();
        exp_cmd_t e;
        bit seen;
        logic [MSGW-1:0] held;
        int base;
        base = cmd_hs_cnt;
        io_cmd_ready = 1'b0;
        @(negedge aclk);
        axi.awaddr = 64'h3004; axi.awvalid = 1'b1;
        axi.wdata = 64'hA5A55A5A12345678; axi.wstrb = 8'h30; axi.wvalid = 1'b1;
        cmd_q.push_back('{UC_WR, 40'h3004, SZ_2, 64'hA5A55A5A12345678});
        bresp_q.push_back(2'b00);
        #1;
        @(negedge aclk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        #1;
        e = cmd_q.pop_front();
        held = io_cmd;
        n_checks++;
        if (io_cmd_v !== 1'b1 || io_cmd !== build_cmd(e)) begin
            n_fail++;
            $display("[TB] FAIL bp_cmd: v %b got %h expected %h", io_cmd_v, io_cmd, build_cmd(e));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk); #1;
            n_checks++;
            if (io_cmd_v !== 1'b1 || io_cmd !== build_cmd(e)) begin
                n_fail++;
                $display("[TB] FAIL bp_hold_%0d: v %b got %h expected %h", i, io_cmd_v, io_cmd, held);
            end
        end
        @(negedge aclk);
        io_cmd_ready = 1'b1;
        #1;
        @(negedge aclk); #1;
        n_checks++;
        if (io_cmd_v !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_cmd_dropped: got %b expected 0", io_cmd_v);
        end
        send_resp(64'h0, seen);
        wait_out(1, seen);
        n_checks++;
        if (seen !== 1'b1 || axi.bresp !== bresp_q.pop_front()) begin
            n_fail++;
            $display("[TB] FAIL bp_bresp: bvalid %b bresp %b expected 1 00", seen, axi.bresp);
        end
        finish_b();
        n_checks++;
        if (cmd_hs_cnt - base !== 1) begin
            n_fail++;
            $display("[TB] FAIL bp_cmd_count: got %0d expected 1", cmd_hs_cnt - base);
        end
    endtask

    task automatic test_bad_strobe();
        bit seen, cmd_seen;
        logic [1:0] eb;
        int base;
        base = cmd_hs_cnt;
        io_cmd_ready = 1'b1;
        @(negedge aclk);
        axi.awaddr = 64'h50; axi.awvalid = 1'b1;
        axi.wdata = 64'h00FF00FF00FF00FF; axi.wstrb = 8'h05; axi.wvalid = 1'b1;
        bresp_q.push_back(2'b10);
        #1;
        @(negedge aclk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        #1;
        seen = 1'b0;
        cmd_seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            if (io_cmd_v === 1'b1) cmd_seen = 1'b1;
            if (axi.bvalid === 1'b1) seen = 1'b1;
            else begin
                @(negedge aclk); #1;
            end
        end
        n_checks++;
        if (cmd_seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bad_strb_no_cmd: got %b expected 0", cmd_seen);
        end
        eb = bresp_q.pop_front();
        n_checks++;
        if (seen !== 1'b1 || axi.bresp !== eb) begin
            n_fail++;
            $display("[TB] FAIL bad_strb_bresp: bvalid %b bresp %b expected 1 %b", seen, axi.bresp, eb);
        end
        finish_b();
        n_checks++;
        if (cmd_hs_cnt - base !== 0) begin
            n_fail++;
            $display("[TB] FAIL bad_strb_cmd_count: got %0d expected 0", cmd_hs_cnt - base);
        end
    endtask

    task automatic test_reset_mid_read();
        exp_cmd_t e;
        bit seen;
        int ybase;
        io_cmd_ready = 1'b1;
        @(negedge aclk);
        axi.araddr = 64'h3000; axi.arvalid = 1'b1;
        cmd_q.push_back('{UC_RD, 40'h3000, SZ_8, 64'h0});
        #1;
        @(negedge aclk);
        axi.arvalid = 1'b0;
        #1;
        wait_out(0, seen);
        e = cmd_q.pop_front();
        n_checks++;
        if (seen !== 1'b1 || io_cmd !== build_cmd(e)) begin
            n_fail++;
            $display("[TB] FAIL rst_rd_cmd: got %h expected %h", io_cmd, build_cmd(e));
        end
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, io_cmd_v, io_resp_yumi,
             axi.bresp, axi.rdata, io_cmd} !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_outputs: ready %b%b%b bv %b rv %b cv %b y %b bresp %b rdata %h expected all 0",
                     axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, io_cmd_v, io_resp_yumi, axi.bresp, axi.rdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        io_resp = '1;
        io_resp_v = 1'b1;
        ybase = yumi_cnt;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({io_resp_yumi, axi.rvalid, io_cmd_v} !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL rst_late_resp_%0d: yumi %b rvalid %b cmd_v %b expected 000", i, io_resp_yumi, axi.rvalid, io_cmd_v);
            end
            @(negedge aclk); #1;
        end
        io_resp_v = 1'b0;
        io_resp = '0;
        @(negedge aclk); #1;
        n_checks++;
        if (yumi_cnt - ybase !== 0) begin
            n_fail++;
            $display("[TB] FAIL rst_yumi_count: got %0d expected 0", yumi_cnt - ybase);
        end
        n_checks++;
        if (cmd_hs_cnt !== 6 || yumi_cnt !== 5) begin
            n_fail++;
            $display("[TB] FAIL total_handshakes: cmds %0d resps %0d expected 6 5", cmd_hs_cnt, yumi_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_aw_first();
        test_simultaneous();
        test_read_hold();
        test_backpressure();
        test_bad_strobe();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
